// File: rtl/playbus_pkg.sv
// ----------------------------------------------------------------------------
// playbus_pkg
// Shared types and defaults for the PlayBus transfer sequencer.
//   src_t   : bus source select (ROM, RAM, switch buffer, reserved)
//   dst_t   : bus sink select (RAM, LED latch, two reserved codes)
//   state_t : sequencer states
//   cmd_legal() : decides whether a src/dst pair may be executed
// Optional feature macro used by the sequencer: PLAYBUS_TURNAROUND_EN
// ----------------------------------------------------------------------------
package playbus_pkg;

   localparam int DEF_ADDR_W = 3;
   localparam int DEF_LEN_W  = 3;

   typedef enum logic [1:0] {
      SRC_ROM  = 2'b00,
      SRC_RAM  = 2'b01,
      SRC_SW   = 2'b10,
      SRC_RSVD = 2'b11
   } src_t;

   typedef enum logic [1:0] {
      DST_RAM   = 2'b00,
      DST_LED   = 2'b01,
      DST_RSVD2 = 2'b10,
      DST_RSVD3 = 2'b11
   } dst_t;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      DRIVE   = 3'd1,
      STROBE  = 3'd2,
      RELEASE = 3'd3,
      REJECT  = 3'd4
   } state_t;

   // RAM->RAM is refused because the RAM cannot drive and capture the
   // same bus in one transfer.
   function automatic logic cmd_legal(input src_t src, input dst_t dst);
      logic dst_ok;
      dst_ok = (dst == DST_RAM) || (dst == DST_LED);
      return (src != SRC_RSVD) && dst_ok && !((src == SRC_RAM) && (dst == DST_RAM));
   endfunction

endpackage

// File: rtl/playbus_addr_ctr.sv
// ----------------------------------------------------------------------------
// playbus_addr_ctr
// Loadable wrapping bus-address counter plus a down-counting word counter.
//   clk, reset : clock and synchronous active-high reset
//   load       : capture load_addr / load_len (start of a burst)
//   step       : advance to next word (address+1 mod 2^ADDR_W, count-1)
//   load_addr  : burst start address
//   load_len   : burst word count minus one
//   address    : current bus address
//   last       : the current word is the final one of the burst
// ----------------------------------------------------------------------------
module playbus_addr_ctr
   import playbus_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int LEN_W  = DEF_LEN_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              step,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [LEN_W-1:0]  load_len,
   output logic [ADDR_W-1:0] address,
   output logic              last
);

   logic [ADDR_W-1:0] addr_reg;
   logic [LEN_W-1:0]  cnt_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         addr_reg <= '0;
         cnt_reg  <= '0;
      end else if (load) begin
         addr_reg <= load_addr;
         cnt_reg  <= load_len;
      end else if (step) begin
         // natural overflow of the ADDR_W-bit register gives the wrap
         addr_reg <= addr_reg + 1'b1;
         cnt_reg  <= cnt_reg - 1'b1;
      end
   end

   assign address = addr_reg;
   assign last    = (cnt_reg == '0);

endmodule

// File: rtl/playbus_ctrl.sv
// ----------------------------------------------------------------------------
// playbus_ctrl
// Bus transfer sequencer for the PlayBus 4-bit shared data bus. Accepts a
// transfer command and walks DRIVE (bus settle) / STROBE (sink capture) per
// word, keeping at most one source enable active in any cycle.
//   clk, reset          : clock, synchronous active-high reset
//   cmd_valid/cmd_ready : command handshake
//   cmd_src, cmd_dst    : source / sink select (see playbus_pkg)
//   cmd_addr, cmd_len   : start address, word count minus one
//   ROMO, RAMO, SWBEN   : source output enables
//   RAMW, LEDLTCH       : sink strobes
//   address             : bus address
//   busy, done, err     : status; done and err are one-cycle pulses
// Optional feature: define PLAYBUS_TURNAROUND_EN to insert a RELEASE cycle
// (enables off, done pulsed) after each burst before returning to IDLE.
// ----------------------------------------------------------------------------
module playbus_ctrl
   import playbus_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int LEN_W  = DEF_LEN_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_src,
   input  logic [1:0]        cmd_dst,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [LEN_W-1:0]  cmd_len,
   output logic              ROMO,
   output logic              RAMO,
   output logic              SWBEN,
   output logic              RAMW,
   output logic              LEDLTCH,
   output logic [ADDR_W-1:0] address,
   output logic              busy,
   output logic              done,
   output logic              err
);

   state_t state_reg;
   dst_t   dst_reg;
   logic   romo_reg, ramo_reg, swben_reg;
   logic   ramw_reg, ledltch_reg;
   logic   busy_reg, done_reg, err_reg, cmd_ready_reg;

   logic       cmd_ok;
   logic       ctr_load, ctr_step, ctr_last;
   logic [2:0] src_sel;

   // One-hot decode of the requested source; the reserved code selects none.
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_src_sel
         assign src_sel[gi] = (cmd_src == 2'(gi));
      end
   endgenerate

   assign cmd_ok   = cmd_legal(src_t'(cmd_src), dst_t'(cmd_dst));
   assign ctr_load = (state_reg == IDLE) && cmd_valid && cmd_ok;
   assign ctr_step = (state_reg == STROBE) && !ctr_last;

   playbus_addr_ctr #(
      .ADDR_W (ADDR_W),
      .LEN_W  (LEN_W)
   ) u_addr_ctr (
      .clk       (clk),
      .reset     (reset),
      .load      (ctr_load),
      .step      (ctr_step),
      .load_addr (cmd_addr),
      .load_len  (cmd_len),
      .address   (address),
      .last      (ctr_last)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         dst_reg       <= DST_RAM;
         romo_reg      <= 1'b0;
         ramo_reg      <= 1'b0;
         swben_reg     <= 1'b0;
         ramw_reg      <= 1'b0;
         ledltch_reg   <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         err_reg       <= 1'b0;
         cmd_ready_reg <= 1'b1;
      end else begin
         case (state_reg)
            IDLE: begin
               done_reg <= 1'b0;
               err_reg  <= 1'b0;
               if (cmd_valid) begin
                  cmd_ready_reg <= 1'b0;
                  if (cmd_ok) begin
                     dst_reg   <= dst_t'(cmd_dst);
                     romo_reg  <= src_sel[0];
                     ramo_reg  <= src_sel[1];
                     swben_reg <= src_sel[2];
                     busy_reg  <= 1'b1;
                     state_reg <= DRIVE;
                  end else begin
                     err_reg   <= 1'b1;
                     state_reg <= REJECT;
                  end
               end
            end

            DRIVE: begin
               // Source has had a full cycle to settle; strobe the sink now.
               ramw_reg    <= (dst_reg == DST_RAM);
               ledltch_reg <= (dst_reg == DST_LED);
               state_reg   <= STROBE;
            end

            STROBE: begin
               ramw_reg    <= 1'b0;
               ledltch_reg <= 1'b0;
               if (!ctr_last) begin
                  // Source enable is left on so the bus never floats mid-burst.
                  state_reg <= DRIVE;
               end else begin
                  romo_reg  <= 1'b0;
                  ramo_reg  <= 1'b0;
                  swben_reg <= 1'b0;
                  done_reg  <= 1'b1;
`ifdef PLAYBUS_TURNAROUND_EN
                  state_reg <= RELEASE;
`else
                  busy_reg      <= 1'b0;
                  cmd_ready_reg <= 1'b1;
                  state_reg     <= IDLE;
`endif
               end
            end

            RELEASE: begin
               done_reg      <= 1'b0;
               busy_reg      <= 1'b0;
               cmd_ready_reg <= 1'b1;
               state_reg     <= IDLE;
            end

            REJECT: begin
               err_reg       <= 1'b0;
               cmd_ready_reg <= 1'b1;
               state_reg     <= IDLE;
            end

            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign ROMO      = romo_reg;
   assign RAMO      = ramo_reg;
   assign SWBEN     = swben_reg;
   assign RAMW      = ramw_reg;
   assign LEDLTCH   = ledltch_reg;
   assign busy      = busy_reg;
   assign done      = done_reg;
   assign err       = err_reg;
   assign cmd_ready = cmd_ready_reg;

endmodule

// File: tb/tb_playbus_ctrl.sv
// ----------------------------------------------------------------------------
// tb_playbus_ctrl
// Self-checking bench for playbus_ctrl. Expected per-cycle outputs come from a
// transaction-level model: a legal burst of L+1 words keeps its source on for
// 2(L+1) cycles, strobes the sink on every second cycle at address
// start+word, then reports done. Honours PLAYBUS_TURNAROUND_EN.
// ----------------------------------------------------------------------------
module tb_playbus_ctrl;

   localparam int ADDR_W = 3;
   localparam int LEN_W  = 3;
   localparam int AMOD   = 1 << ADDR_W;
`ifdef PLAYBUS_TURNAROUND_EN
   localparam int TA = 1;
`else
   localparam int TA = 0;
`endif

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              cmd_valid = 1'b0;
   logic [1:0]        cmd_src = '0;
   logic [1:0]        cmd_dst = '0;
   logic [ADDR_W-1:0] cmd_addr = '0;
   logic [LEN_W-1:0]  cmd_len = '0;
   logic              cmd_ready, ROMO, RAMO, SWBEN, RAMW, LEDLTCH;
   logic              busy, done, err;
   logic [ADDR_W-1:0] address;

   int n_tests = 0;
   int n_fail  = 0;
   int txn     = 0;
   int model_addr = 0;
   bit inv_en  = 1'b0;

   playbus_ctrl #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_src   (cmd_src),
      .cmd_dst   (cmd_dst),
      .cmd_addr  (cmd_addr),
      .cmd_len   (cmd_len),
      .ROMO      (ROMO),
      .RAMO      (RAMO),
      .SWBEN     (SWBEN),
      .RAMW      (RAMW),
      .LEDLTCH   (LEDLTCH),
      .address   (address),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Output vector order: {ROMO,RAMO,SWBEN,RAMW,LEDLTCH,busy,done,err,cmd_ready}
   task automatic chk_cycle(input string tag, input logic [8:0] exp, input int exp_addr);
      check({tag, "_outs"}, {23'd0, ROMO, RAMO, SWBEN, RAMW, LEDLTCH, busy, done, err, cmd_ready},
            {23'd0, exp});
      check({tag, "_addr"}, {29'd0, address}, exp_addr % AMOD);
   endtask

   task automatic idle(input int cycles);
      cmd_valid = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         chk_cycle("idle", 9'b000000001, model_addr);
      end
   endtask

   // Issue one command at the current negedge (DUT expected ready) and check
   // every cycle of its expected trace. Returns at the first cycle in which
   // the DUT is ready again. abort_at>0 raises reset after that cycle.
   task automatic issue(input int src, input int dst, input int addr, input int len,
                        input bit hold, input int abort_at);
      bit         legal;
      int         n, words;
      logic [8:0] e;
      int         ea;
      legal = (src != 3) && (dst < 2) && !(src == 1 && dst == 0);
      words = len + 1;
      n     = legal ? (2 * words + 1 + TA) : 2;
      cmd_src   = 2'(src);
      cmd_dst   = 2'(dst);
      cmd_addr  = ADDR_W'(addr);
      cmd_len   = LEN_W'(len);
      cmd_valid = 1'b1;
      txn++;
      $display("[TB] txn %0d src=%0d dst=%0d addr=%0d len=%0d legal=%0d hold=%0d",
               txn, src, dst, addr, len, legal, hold);
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         if (!hold) cmd_valid = 1'b0;
         e = '0;
         if (!legal) begin
            ea = model_addr;
            if (k == 1) e[1] = 1'b1;
            else        e[0] = 1'b1;
         end else if (k <= 2 * words) begin
            e[8 - src] = 1'b1;
            if (k % 2 == 0) e[(dst == 0) ? 5 : 4] = 1'b1;
            e[3] = 1'b1;
            ea = addr + (k - 1) / 2;
         end else if (k == 2 * words + 1) begin
            e[2] = 1'b1;
            if (TA != 0) e[3] = 1'b1;
            else         e[0] = 1'b1;
            ea = addr + len;
         end else begin
            e[0] = 1'b1;
            ea = addr + len;
         end
         chk_cycle($sformatf("t%0d_k%0d", txn, k), e, ea);
         if (k == abort_at) begin
            cmd_valid = 1'b0;
            reset     = 1'b1;
            return;
         end
      end
      if (legal) model_addr = (addr + len) % AMOD;
   endtask

   // Bus invariants, every cycle.
   always @(negedge clk) begin
      if (inv_en && !reset) begin
         int s;
         s = int'(ROMO) + int'(RAMO) + int'(SWBEN);
         check("src_onehot", (s <= 1) ? 32'd1 : 32'd0, 32'd1);
         check("strobe_src", {31'd0, (RAMW | LEDLTCH) & ~(ROMO | RAMO | SWBEN)}, 32'd0);
         check("strobe_pair", {31'd0, RAMW & LEDLTCH}, 32'd0);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int  src, dst, addr, len, gap;
      bit  hold;
      bit  prev_hold;

      // Reset state
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_cycle("reset", 9'b000000001, 0);
      reset  = 1'b0;
      inv_en = 1'b1;
      idle(2);

      // ROM -> LED, single word at 5
      issue(0, 1, 5, 0, 1'b0, 0);
      idle(1);
      // SW -> RAM burst wrapping 6,7,0,1 then RAM -> LED read back
      issue(2, 0, 6, 3, 1'b0, 0);
      issue(1, 1, 6, 3, 1'b0, 0);
      idle(1);
      // Illegal commands
      issue(1, 0, 2, 1, 1'b0, 0);
      issue(3, 1, 4, 0, 1'b0, 0);
      issue(0, 2, 4, 0, 1'b0, 0);
      idle(1);
      // Reset during the second STROBE of a 3-word burst
      issue(0, 0, 3, 2, 1'b0, 4);
      @(negedge clk);
      model_addr = 0;
      chk_cycle("rst_mid", 9'b000000001, 0);
      reset = 1'b0;
      idle(4);

      // Randomised traffic, including held cmd_valid back-to-back
      prev_hold = 1'b0;
      src = 0; dst = 0; addr = 0; len = 0;
      for (int t = 0; t < 60; t++) begin
         if (!prev_hold) begin
            src  = $urandom_range(0, 3);
            dst  = ($urandom_range(0, 7) < 6) ? $urandom_range(0, 1) : $urandom_range(2, 3);
            addr = $urandom_range(0, AMOD - 1);
            len  = $urandom_range(0, (1 << LEN_W) - 1);
            gap  = $urandom_range(0, 2);
            if (gap > 0) idle(gap);
         end
         hold = ($urandom_range(0, 3) == 0);
         issue(src, dst, addr, len, hold, 0);
         prev_hold = hold;
      end
      if (prev_hold) issue(src, dst, addr, len, 1'b0, 0);
      idle(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
